pedometer_sched: RTL and testbench

Front-end scheduler for the pedometer datapath. It arbitrates between a sensor sample stream (A/B pairs) and two weight-write requesters: requester 0 is the host config port and requester 1 is the calibration engine. It drives the pedometer's countSteps / updateWeight / dualUpdateWeights strobes and the A, B, Addr1/2 and Data1/2 buses. At most one datapath operation is issued per cycle, and weight writes are merged into dual updates where legal.

---
 rtl/pedometer_sched.sv | 146 ++++++++++++++
 tb/tb_pedometer_sched.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pedometer_sched.sv
// Front-end scheduler for the pedometer datapath: arbitrates a sample stream against
// two weight-write requesters and issues at most one registered datapath strobe per cycle.
module pedometer_sched #(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 3,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              smp_valid,
   input  logic [DATA_W-1:0] smp_a,
   input  logic [DATA_W-1:0] smp_b,
   output logic              smp_ready,
   input  logic              w0_valid,
   input  logic [ADDR_W-1:0] w0_addr,
   input  logic [DATA_W-1:0] w0_data,
   output logic              w0_ready,
   input  logic              w1_valid,
   input  logic [ADDR_W-1:0] w1_addr,
   input  logic [DATA_W-1:0] w1_data,
   output logic              w1_ready,
   output logic              countSteps,
   output logic              updateWeight,
   output logic              dualUpdateWeights,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [ADDR_W-1:0] Addr1,
   output logic [ADDR_W-1:0] Addr2,
   output logic [DATA_W-1:0] Data1,
   output logic [DATA_W-1:0] Data2,
   output logic              starved
);

   typedef enum logic {
      CFG = 1'b0,
      RUN = 1'b1
   } state_t;

   localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [3:0] starve_r;
   logic [3:0] starve_nxt_s;
   logic       at_limit_s;
   logic       w_allowed_s;
   logic       smp_go_s;
   logic       w0_go_s;
   logic       w1_go_s;

   assign smp_ready = smp_go_s;
   assign w0_ready  = w0_go_s;
   assign w1_ready  = w1_go_s;

   // Grant decision, next state and starve counter update for the current cycle.
   always_comb begin
      state_nxt_s  = state_r;
      starve_nxt_s = 4'd0;
      w_allowed_s  = 1'b1;
      smp_go_s     = 1'b0;
      w0_go_s      = 1'b0;
      w1_go_s      = 1'b0;
      at_limit_s   = (starve_r == LIMIT_C);

      // A starved requester overrides the default sample priority in RUN.
      if (state_r == RUN) begin
         w_allowed_s = !smp_valid || at_limit_s;
         smp_go_s    = smp_valid && !at_limit_s;
      end else begin
         w_allowed_s = 1'b1;
         smp_go_s    = 1'b0;
      end

      if (reset) begin
         smp_go_s = 1'b0;
         w0_go_s  = 1'b0;
         w1_go_s  = 1'b0;
      end else begin
         w0_go_s = w_allowed_s && w0_valid;
         // Same-address writes cannot merge; requester 1 waits for a later slot.
         w1_go_s = w_allowed_s && w1_valid && !(w0_valid && (w0_addr == w1_addr));
      end

      case (state_r)
         CFG: begin
            if (enable) state_nxt_s = RUN;
            else        state_nxt_s = CFG;
         end
         RUN: begin
            if (!enable) state_nxt_s = CFG;
            else         state_nxt_s = RUN;
         end
         default: state_nxt_s = CFG;
      endcase

      if ((state_r == RUN) && (w0_valid || w1_valid) && !(w0_go_s || w1_go_s)) begin
         if (at_limit_s) starve_nxt_s = starve_r;
         else            starve_nxt_s = starve_r + 4'd1;
      end else begin
         starve_nxt_s = 4'd0;
      end
   end

   // State, starve counter and registered datapath strobes/buses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r           <= CFG;
         starve_r          <= 4'd0;
         starved           <= 1'b0;
         countSteps        <= 1'b0;
         updateWeight      <= 1'b0;
         dualUpdateWeights <= 1'b0;
         A                 <= '0;
         B                 <= '0;
         Addr1             <= '0;
         Addr2             <= '0;
         Data1             <= '0;
         Data2             <= '0;
      end else begin
         state_r           <= state_nxt_s;
         starve_r          <= starve_nxt_s;
         starved           <= at_limit_s;
         countSteps        <= smp_go_s;
         updateWeight      <= w0_go_s ^ w1_go_s;
         dualUpdateWeights <= w0_go_s & w1_go_s;
         if (smp_go_s) begin
            A <= smp_a;
            B <= smp_b;
         end
         // Slot 1 prefers requester 0; slot 2 is only used by a merged dual write.
         if (w0_go_s) begin
            Addr1 <= w0_addr;
            Data1 <= w0_data;
         end else if (w1_go_s) begin
            Addr1 <= w1_addr;
            Data1 <= w1_data;
         end
         if (w0_go_s && w1_go_s) begin
            Addr2 <= w1_addr;
            Data2 <= w1_data;
         end
      end
   end

endmodule

// File: tb/tb_pedometer_sched.sv
// Directed, table-driven bench for pedometer_sched: each record drives one cycle, checks the
// combinational readies before the edge and the registered strobes/buses after it.
module tb_pedometer_sched;

   logic       clk = 1'b0;
   logic       reset, enable, smp_valid, w0_valid, w1_valid;
   logic [7:0] smp_a, smp_b, w0_data, w1_data;
   logic [2:0] w0_addr, w1_addr;
   logic       smp_ready, w0_ready, w1_ready;
   logic       countSteps, updateWeight, dualUpdateWeights, starved;
   logic [7:0] A, B, Data1, Data2;
   logic [2:0] Addr1, Addr2;

   int applied = 0;
   int miscompares = 0;

   typedef struct {
      logic       rst, en, sv;
      logic [7:0] sa, sb;
      logic       v0;
      logic [2:0] a0;
      logic [7:0] d0;
      logic       v1;
      logic [2:0] a1;
      logic [7:0] d1;
      logic       e_sr, e_r0, e_r1, e_cs, e_uw, e_du;
      logic [7:0] e_a, e_b;
      logic [2:0] e_ad1, e_ad2;
      logic [7:0] e_d1, e_d2;
      logic       e_st;
   } vec_t;

   vec_t tbl[$];

   pedometer_sched #(.STARVE_LIMIT(4), .ADDR_W(3), .DATA_W(8)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .smp_valid(smp_valid), .smp_a(smp_a), .smp_b(smp_b), .smp_ready(smp_ready),
      .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
      .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
      .countSteps(countSteps), .updateWeight(updateWeight),
      .dualUpdateWeights(dualUpdateWeights),
      .A(A), .B(B), .Addr1(Addr1), .Addr2(Addr2), .Data1(Data1), .Data2(Data2),
      .starved(starved)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL vec%0d %s: got %0h expected %0h", idx, nm, act, exp);
      end
   endtask

   task automatic add(input logic rst, en, sv, input logic [7:0] sa, sb,
                      input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                      input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                      input logic sr, r0, r1, cs, uw, du,
                      input logic [7:0] ea, eb, input logic [2:0] ad1, input logic [7:0] ed1,
                      input logic [2:0] ad2, input logic [7:0] ed2, input logic st);
      vec_t v;
      v.rst = rst; v.en = en; v.sv = sv; v.sa = sa; v.sb = sb;
      v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.e_sr = sr; v.e_r0 = r0; v.e_r1 = r1; v.e_cs = cs; v.e_uw = uw; v.e_du = du;
      v.e_a = ea; v.e_b = eb; v.e_ad1 = ad1; v.e_d1 = ed1; v.e_ad2 = ad2; v.e_d2 = ed2;
      v.e_st = st;
      tbl.push_back(v);
   endtask

   // Drive on the falling edge, check readies, then check registered outputs 1ns after the rising edge.
   task automatic apply(input int idx, input vec_t v);
      @(negedge clk);
      reset = v.rst; enable = v.en; smp_valid = v.sv; smp_a = v.sa; smp_b = v.sb;
      w0_valid = v.v0; w0_addr = v.a0; w0_data = v.d0;
      w1_valid = v.v1; w1_addr = v.a1; w1_data = v.d1;
      #1;
      chk("smp_ready", idx, {7'd0, smp_ready}, {7'd0, v.e_sr});
      chk("w0_ready", idx, {7'd0, w0_ready}, {7'd0, v.e_r0});
      chk("w1_ready", idx, {7'd0, w1_ready}, {7'd0, v.e_r1});
      @(posedge clk);
      #1;
      chk("countSteps", idx, {7'd0, countSteps}, {7'd0, v.e_cs});
      chk("updateWeight", idx, {7'd0, updateWeight}, {7'd0, v.e_uw});
      chk("dualUpdateWeights", idx, {7'd0, dualUpdateWeights}, {7'd0, v.e_du});
      chk("A", idx, A, v.e_a);
      chk("B", idx, B, v.e_b);
      chk("Addr1", idx, {5'd0, Addr1}, {5'd0, v.e_ad1});
      chk("Data1", idx, Data1, v.e_d1);
      chk("Addr2", idx, {5'd0, Addr2}, {5'd0, v.e_ad2});
      chk("Data2", idx, Data2, v.e_d2);
      chk("starved", idx, {7'd0, starved}, {7'd0, v.e_st});
   endtask

   initial begin
      vec_t hv;
      reset = 1'b1; enable = 1'b0; smp_valid = 1'b0; smp_a = 8'h00; smp_b = 8'h00;
      w0_valid = 1'b0; w0_addr = 3'd0; w0_data = 8'h00;
      w1_valid = 1'b0; w1_addr = 3'd0; w1_data = 8'h00;

      //   rst en sv  sa     sb     v0 a0   d0     v1 a1   d1     sr r0 r1 cs uw du  A      B      ad1  d1     ad2  d2     st
      // reset: readies forced low, everything cleared
      add(1, 0, 1, 8'h77, 8'h78, 1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 3'd0, 8'h00, 0);
      // CFG: single w0 write, sample refused
      add(0, 0, 1, 8'h77, 8'h78, 1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 3'd3, 8'h5A, 3'd0, 8'h00, 0);
      // idle: strobes drop, buses hold
      add(0, 0, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd3, 8'h5A, 3'd0, 8'h00, 0);
      // dual merge on distinct addresses
      add(0, 0, 0, 8'h00, 8'h00, 1, 3'd2, 8'h11, 1, 3'd5, 8'h22, 0, 1, 1, 0, 0, 1, 8'h00, 8'h00, 3'd2, 8'h11, 3'd5, 8'h22, 0);
      // same address: w0 first, w1 next slot
      add(0, 0, 0, 8'h00, 8'h00, 1, 3'd4, 8'hAA, 1, 3'd4, 8'hBB, 0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 3'd4, 8'hAA, 3'd5, 8'h22, 0);
      add(0, 0, 0, 8'h00, 8'h00, 0, 3'd4, 8'hAA, 1, 3'd4, 8'hBB, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 3'd4, 8'hBB, 3'd5, 8'h22, 0);
      // enable raised; still CFG this cycle
      add(0, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd4, 8'hBB, 3'd5, 8'h22, 0);
      // RUN: continuous samples starve w1 for STARVE_LIMIT cycles
      add(0, 1, 1, 8'h10, 8'h20, 0, 3'd0, 8'h00, 1, 3'd6, 8'h3C, 1, 0, 0, 1, 0, 0, 8'h10, 8'h20, 3'd4, 8'hBB, 3'd5, 8'h22, 0);
      add(0, 1, 1, 8'h11, 8'h21, 0, 3'd0, 8'h00, 1, 3'd6, 8'h3C, 1, 0, 0, 1, 0, 0, 8'h11, 8'h21, 3'd4, 8'hBB, 3'd5, 8'h22, 0);
      add(0, 1, 1, 8'h12, 8'h22, 0, 3'd0, 8'h00, 1, 3'd6, 8'h3C, 1, 0, 0, 1, 0, 0, 8'h12, 8'h22, 3'd4, 8'hBB, 3'd5, 8'h22, 0);
      add(0, 1, 1, 8'h13, 8'h23, 0, 3'd0, 8'h00, 1, 3'd6, 8'h3C, 1, 0, 0, 1, 0, 0, 8'h13, 8'h23, 3'd4, 8'hBB, 3'd5, 8'h22, 0);
      // forced weight slot, starved visible the next cycle
      add(0, 1, 1, 8'h14, 8'h24, 0, 3'd0, 8'h00, 1, 3'd6, 8'h3C, 0, 0, 1, 0, 1, 0, 8'h13, 8'h23, 3'd6, 8'h3C, 3'd5, 8'h22, 1);
      add(0, 1, 1, 8'h15, 8'h25, 0, 3'd0, 8'h00, 0, 3'd6, 8'h3C, 1, 0, 0, 1, 0, 0, 8'h15, 8'h25, 3'd6, 8'h3C, 3'd5, 8'h22, 0);
      // RUN with no sample: weight granted straight away
      add(0, 1, 0, 8'h00, 8'h00, 1, 3'd1, 8'h99, 0, 3'd0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h15, 8'h25, 3'd1, 8'h99, 3'd5, 8'h22, 0);

      for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

      // Reset mid-operation: sample accepted, then reset wipes the following strobe and buses.
      add(0, 1, 1, 8'h42, 8'h43, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h42, 8'h43, 3'd1, 8'h99, 3'd5, 8'h22, 0);
      apply(100, tbl[tbl.size()-1]);
      add(1, 1, 1, 8'h44, 8'h45, 1, 3'd2, 8'h12, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 3'd0, 8'h00, 0);
      apply(101, tbl[tbl.size()-1]);
      // back in CFG: sample refused even with enable high
      add(0, 1, 1, 8'h46, 8'h47, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 3'd0, 8'h00, 0);
      apply(102, tbl[tbl.size()-1]);

      // Enable dropped in the accepting cycle: strobe still issues, then CFG grants weights.
      hv = tbl[tbl.size()-1];
      hv.en = 1'b0; hv.sa = 8'h51; hv.sb = 8'h52;
      hv.e_sr = 1'b1; hv.e_cs = 1'b1; hv.e_a = 8'h51; hv.e_b = 8'h52;
      apply(103, hv);
      hv.sa = 8'h53; hv.sb = 8'h54; hv.v0 = 1'b1; hv.a0 = 3'd7; hv.d0 = 8'hE1;
      hv.e_sr = 1'b0; hv.e_r0 = 1'b1; hv.e_cs = 1'b0; hv.e_uw = 1'b1;
      hv.e_ad1 = 3'd7; hv.e_d1 = 8'hE1;
      apply(104, hv);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
